riscv_decode_stage: RTL and testbench

Registered RV32I/RV32E decode pipeline stage. Sits between fetch and execute and decodes one 32-bit instruction per accepted beat. Produces register indices, the instruction format, a fully sign-extended immediate for every format (I/S/B/U/J) and an illegal-instruction flag. Uses valid/ready handshakes on both sides, with a one-entry skid buffer so that in_ready is a registered signal.

---
 rtl/riscv_decode_stage.sv | 205 ++++++++++++++++++++
 tb/tb_riscv_decode_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_decode_stage.sv
// RV32I/RV32E decode stage: one instruction per beat into a registered decode result, with a one-entry skid buffer.
// Latency: 1 cycle from input transfer to out_valid; sustained 1/cycle while out_ready is high.
// Backpressure: in_ready = !skid_full, from a flop; a stalled output parks one more result in the skid entry. Optional macro DECODE_PERF_CNT_EN adds perf counters.
module riscv_decode_stage #(
  parameter int XLEN       = 32,
  parameter int PC_W       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [PC_W-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_W-1:0]       out_pc,
  output logic [6:0]            out_opcode,
  output logic [2:0]            out_fmt,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [2:0]            out_funct3,
  output logic [6:0]            out_funct7,
  output logic [XLEN-1:0]       out_imm,
`ifdef DECODE_PERF_CNT_EN
  output logic [31:0]           perf_decoded,
  output logic [31:0]           perf_illegal,
`endif
  output logic                  out_illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [6:0]            opcode;
    logic [2:0]            fmt;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [XLEN-1:0]       imm;
    logic                  illegal;
  } dec_t;

  dec_t               dec;
  dec_t               out_reg;
  dec_t               skid_reg;
  logic               out_full;
  logic               skid_full;
  logic               in_xfer;
  logic               out_xfer;
  logic [2:0]         fmt_raw;
  logic               bad_opcode;
  logic               use_rd;
  logic               use_rs1;
  logic               use_rs2;
  logic               bad_regs;
  logic signed [31:0] imm32;

  assign in_ready = !skid_full;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_full && out_ready;

  // Combinational decode of the presented instruction.
  always_comb begin
    fmt_raw    = FMT_ILL;
    bad_opcode = 1'b0;
    use_rd     = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    imm32      = '0;
    case (in_instr[6:0])
      7'b0110011: begin
        fmt_raw = FMT_R;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        fmt_raw = FMT_I;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        fmt_raw = FMT_S;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        fmt_raw = FMT_B;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt_raw = FMT_U;
        use_rd  = 1'b1;
        imm32   = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        fmt_raw = FMT_J;
        use_rd  = 1'b1;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      end
      default: bad_opcode = 1'b1;
    endcase

    // RV32E only has x0-x15: the top index bit of any field the format actually uses must be clear.
    bad_regs = (REG_ADDR_W == 4) &&
               ((use_rd && in_instr[11]) || (use_rs1 && in_instr[19]) || (use_rs2 && in_instr[24]));

    dec         = '0;
    dec.pc      = in_pc;
    dec.opcode  = in_instr[6:0];
    dec.rd      = in_instr[7 +: REG_ADDR_W];
    dec.rs1     = in_instr[15 +: REG_ADDR_W];
    dec.rs2     = in_instr[20 +: REG_ADDR_W];
    dec.funct3  = in_instr[14:12];
    dec.funct7  = in_instr[31:25];
    dec.illegal = bad_opcode || (in_instr[1:0] != 2'b11) || bad_regs;
    if (dec.illegal) begin
      dec.fmt = FMT_ILL;
      dec.imm = '0;
    end else begin
      dec.fmt = fmt_raw;
      dec.imm = XLEN'(imm32);
    end
  end

  // Output register plus skid entry; skid refills the output first so order is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_full  <= 1'b0;
      skid_full <= 1'b0;
      out_reg   <= '0;
      skid_reg  <= '0;
    end else if (flush) begin
      out_full  <= 1'b0;
      skid_full <= 1'b0;
    end else if (!out_full || out_ready) begin
      if (skid_full) begin
        out_reg   <= skid_reg;
        out_full  <= 1'b1;
        skid_full <= 1'b0;
      end else if (in_xfer) begin
        out_reg  <= dec;
        out_full <= 1'b1;
      end else begin
        out_full <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_reg  <= dec;
      skid_full <= 1'b1;
    end
  end

  assign out_valid   = out_full;
  assign out_pc      = out_reg.pc;
  assign out_opcode  = out_reg.opcode;
  assign out_fmt     = out_reg.fmt;
  assign out_rd      = out_reg.rd;
  assign out_rs1     = out_reg.rs1;
  assign out_rs2     = out_reg.rs2;
  assign out_funct3  = out_reg.funct3;
  assign out_funct7  = out_reg.funct7;
  assign out_imm     = out_reg.imm;
  assign out_illegal = out_reg.illegal;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_dec_cnt;
  logic [31:0] perf_ill_cnt;

  // Count delivered beats; a beat killed by a same-cycle flush is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_dec_cnt <= '0;
      perf_ill_cnt <= '0;
    end else if (out_xfer && !flush) begin
      perf_dec_cnt <= perf_dec_cnt + 32'd1;
      if (out_reg.illegal) perf_ill_cnt <= perf_ill_cnt + 32'd1;
    end
  end

  assign perf_decoded = perf_dec_cnt;
  assign perf_illegal = perf_ill_cnt;
`else
  logic unused_out_xfer;
  assign unused_out_xfer = out_xfer;
`endif

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: constant vector table, scoreboard queue, backpressure/flush sequences.
// A second instance with REG_ADDR_W=4 checks RV32E register-range rules.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_riscv_decode_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_fmt, out_funct3;
  logic [4:0]  out_rd, out_rs1, out_rs2;

  logic        e_in_valid, e_in_ready, e_out_valid, e_out_illegal;
  logic [31:0] e_in_instr, e_out_pc, e_out_imm;
  logic [6:0]  e_out_opcode, e_out_funct7;
  logic [2:0]  e_out_fmt, e_out_funct3;
  logic [3:0]  e_out_rd, e_out_rs1, e_out_rs2;

  riscv_decode_stage #(.XLEN(32), .PC_W(32), .REG_ADDR_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_fmt(out_fmt), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );

  riscv_decode_stage #(.XLEN(32), .PC_W(32), .REG_ADDR_W(4)) u_dut_e (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .in_instr(e_in_instr), .in_pc(32'h0000_2000), .out_valid(e_out_valid), .out_ready(1'b1),
    .out_pc(e_out_pc), .out_opcode(e_out_opcode), .out_fmt(e_out_fmt), .out_rd(e_out_rd),
    .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_funct3(e_out_funct3), .out_funct7(e_out_funct7),
    .out_imm(e_out_imm), .out_illegal(e_out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t tbl[11];
  vec_t sbq[$];
  vec_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   nout   = 0;
  int   cur    = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input int idx, input logic [2:0] fmt,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic ill);
    vec_t v;
    v.instr = instr; v.pc = 32'h1000 + 32'(idx * 4); v.fmt = fmt;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7; v.imm = imm; v.ill = ill;
    return v;
  endfunction

  // Scoreboard: compare on output transfer, check hold while stalled, push on input transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) begin
        nout++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_output: got pc %0h expected no output", out_pc);
        end else begin
          mon_e = sbq.pop_front();
          chk("pc",      out_pc,      mon_e.pc);
          chk("opcode",  out_opcode,  mon_e.instr[6:0]);
          chk("fmt",     out_fmt,     mon_e.fmt);
          chk("rd",      out_rd,      mon_e.rd);
          chk("rs1",     out_rs1,     mon_e.rs1);
          chk("rs2",     out_rs2,     mon_e.rs2);
          chk("funct3",  out_funct3,  mon_e.f3);
          chk("funct7",  out_funct7,  mon_e.f7);
          chk("imm",     out_imm,     mon_e.imm);
          chk("illegal", out_illegal, mon_e.ill);
        end
      end else if (out_valid && sbq.size() > 0) begin
        chk("hold_pc", out_pc, sbq[0].pc);
      end
      if (flush) sbq.delete();
      else if (in_valid && in_ready) sbq.push_back(tbl[cur]);
    end
  end

  task automatic present(input int idx);
    cur      = idx;
    in_valid = 1'b1;
    in_instr = tbl[idx].instr;
    in_pc    = tbl[idx].pc;
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    chk("accept_in_time", ok, 1);
  endtask

  task automatic send(input int idx);
    present(idx);
    wait_accept();
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (sbq.size() == 0) break;
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  task automatic e_send(input logic [31:0] instr, input logic [2:0] fmt, input logic ill,
                        input logic [31:0] imm, input logic [3:0] rd);
    @(posedge clk); #1;
    e_in_valid = 1'b1;
    e_in_instr = instr;
    @(negedge clk);
    chk("e_in_ready", e_in_ready, 1);
    @(posedge clk); #1;
    e_in_valid = 1'b0;
    @(negedge clk);
    chk("e_out_valid", e_out_valid, 1);
    chk("e_fmt",       e_out_fmt,   fmt);
    chk("e_illegal",   e_out_illegal, ill);
    chk("e_imm",       e_out_imm,   imm);
    chk("e_rd",        e_out_rd,    rd);
  endtask

  initial begin
    int n0;
    tbl[0]  = mk(32'hFFF10093, 0,  3'd1, 5'd1,  5'd2,  5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 1'b0);
    tbl[1]  = mk(32'h00512423, 1,  3'd2, 5'd8,  5'd2,  5'd5,  3'd2, 7'h00, 32'h00000008, 1'b0);
    tbl[2]  = mk(32'hFE000EE3, 2,  3'd3, 5'd29, 5'd0,  5'd0,  3'd0, 7'h7F, 32'hFFFFFFFC, 1'b0);
    tbl[3]  = mk(32'h123452B7, 3,  3'd4, 5'd5,  5'd8,  5'd3,  3'd5, 7'h09, 32'h12345000, 1'b0);
    tbl[4]  = mk(32'h0000006F, 4,  3'd5, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, 1'b0);
    tbl[5]  = mk(32'h00000000, 5,  3'd7, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, 1'b1);
    tbl[6]  = mk(32'h00B50533, 6,  3'd0, 5'd10, 5'd10, 5'd11, 3'd0, 7'h00, 32'h00000000, 1'b0);
    tbl[7]  = mk(32'hFFF10092, 7,  3'd7, 5'd1,  5'd2,  5'd31, 3'd0, 7'h7F, 32'h00000000, 1'b1);
    tbl[8]  = mk(32'h00001017, 8,  3'd4, 5'd0,  5'd0,  5'd0,  3'd1, 7'h00, 32'h00001000, 1'b0);
    tbl[9]  = mk(32'h8000006F, 9,  3'd5, 5'd0,  5'd0,  5'd0,  3'd0, 7'h40, 32'hFFF00000, 1'b0);
    tbl[10] = mk(32'h80002083, 10, 3'd1, 5'd1,  5'd0,  5'd0,  3'd2, 7'h40, 32'hFFFFF800, 1'b0);

    // Reset held with fetch presenting an instruction.
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    e_in_valid = 1'b0; e_in_instr = '0;
    present(0);
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_imm",   out_imm,   0);
    chk("rst_out_pc",    out_pc,    0);
    chk("rst_out_fmt",   out_fmt,   0);
    chk("rst_e_out_valid", e_out_valid, 0);
    rst_n = 1'b1;
    idle();
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Back-to-back stream of the whole table.
    send(0);
    @(negedge clk);
    chk("latency_out_valid", out_valid, 1);
    @(posedge clk); #1;
    for (int i = 1; i < 11; i++) send(i);
    idle();
    drain();

    // Backpressure: two accepted, third waits for the stall to clear.
    @(posedge clk); #1;
    out_ready = 1'b0;
    n0 = nout;
    send(3);
    send(4);
    present(6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid",    out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept();
    idle();
    drain();
    chk("bp_out_count", nout - n0, 3);

    // Flush with output and skid both full.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(0);
    send(1);
    present(2);
    flush = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    @(negedge clk);
    chk("flush1_out_valid", out_valid, 0);
    chk("flush1_in_ready",  in_ready,  1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush1_quiet", out_valid, 0);
    end

    // Flush in the same cycle as an input transfer: that beat is dropped.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3);
    present(4);
    flush = 1'b1;
    @(negedge clk);
    chk("flush2_in_ready_during", in_ready, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    @(negedge clk);
    chk("flush2_out_valid", out_valid, 0);
    chk("flush2_in_ready",  in_ready,  1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush2_quiet", out_valid, 0);
    end
    @(posedge clk); #1;
    send(6);
    idle();
    drain();

    // RV32E register range on the REG_ADDR_W=4 instance.
    e_send(32'h00000813, 3'd7, 1'b1, 32'h00000000, 4'd0);
    e_send(32'h00100093, 3'd1, 1'b0, 32'h00000001, 4'd1);
    e_send(32'h00012823, 3'd2, 1'b0, 32'h00000010, 4'd0);
    e_send(32'h01000033, 3'd7, 1'b1, 32'h00000000, 4'd0);
    e_send(32'h00000000, 3'd7, 1'b1, 32'h00000000, 4'd0);

    @(negedge clk);
    chk("final_sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
